// File: rtl/mealy_stream_sched.sv
// Round-robin scheduler that time-shares one Mealy sequence detector between two
// word requesters: load a word, clear the detector, shift LSB-first, report hits.
module mealy_stream_sched #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_rst,
  output logic             det_inp,
  input  logic             det_outp,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNTW-1:0]  res_count,
  output logic [WIDTH-1:0] res_mask,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [IDXW-1:0]  idx;
  logic [CNTW-1:0]  count;
  logic [WIDTH-1:0] mask;
  logic             id;
  logic             last_grant;

  // Result copies: count/mask are cleared on the next accept, but the result
  // outputs must keep the last job's values until the following DONE.
  logic             hold_id;
  logic [CNTW-1:0]  hold_count;
  logic [WIDTH-1:0] hold_mask;

  logic grant0, grant1;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = rst && (state == IDLE) && grant0;
  assign req1_ready = rst && (state == IDLE) && grant1;
  assign det_rst    = !rst || (state == CLR);
  assign det_inp    = rst && (state == SHIFT) && shreg[0];
  assign res_valid  = rst && (state == DONE);
  assign busy       = rst && (state != IDLE);
  assign res_id     = (state == DONE) ? id    : hold_id;
  assign res_count  = (state == DONE) ? count : hold_count;
  assign res_mask   = (state == DONE) ? mask  : hold_mask;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = CLR;
      CLR:     state_nxt = SHIFT;
      SHIFT:   if (idx == IDXW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      shreg      <= '0;
      idx        <= '0;
      count      <= '0;
      mask       <= '0;
      id         <= 1'b0;
      hold_id    <= 1'b0;
      hold_count <= '0;
      hold_mask  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            shreg      <= grant0 ? req0_data : req1_data;
            id         <= grant1;
            last_grant <= grant1;
            count      <= '0;
            mask       <= '0;
            idx        <= '0;
          end
        end
        SHIFT: begin
          mask[idx] <= det_outp;
          count     <= count + CNTW'(det_outp);
          shreg     <= {1'b0, shreg[WIDTH-1:1]};
          idx       <= idx + IDXW'(1);
        end
        DONE: begin
          hold_id    <= id;
          hold_count <= count;
          hold_mask  <= mask;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mealy_stream_sched.sv
// Directed bench for mealy_stream_sched; the detector is modelled as an echo
// (det_outp = det_inp), so each result is the word itself and its popcount.
module tb_mealy_stream_sched;

  localparam int WIDTH = 16;
  localparam int CNTW  = 5;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             det_rst, det_inp, det_outp;
  logic             res_valid, res_id, busy;
  logic [CNTW-1:0]  res_count;
  logic [WIDTH-1:0] res_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign det_outp = det_inp;

  mealy_stream_sched #(.WIDTH(WIDTH), .CNTW(CNTW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_rst(det_rst), .det_inp(det_inp), .det_outp(det_outp),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .res_mask(res_mask), .busy(busy)
  );

  // Advance to the next cycle; outputs are then read 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_data = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({req0_ready, req1_ready, det_rst, res_valid, busy, det_inp} !== 6'b001000) begin
        errors++;
        $display("FAIL reset_ctrl c%0d: r0rdy=%b r1rdy=%b det_rst=%b res_valid=%b busy=%b det_inp=%b, want 0 0 1 0 0 0",
                 c, req0_ready, req1_ready, det_rst, res_valid, busy, det_inp);
      end
    end
    checks++;
    if (res_count !== 5'd0 || res_mask !== 16'h0000) begin
      errors++;
      $display("FAIL reset_res: count=%0d mask=%h, want 0 0000", res_count, res_mask);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || det_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b det_rst=%b, want 0 0", busy, det_rst);
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] word;
    word = 16'h5772;
    req0_valid = 1'b1; req0_data = word;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: r0rdy=%b r1rdy=%b, want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (det_rst !== 1'b1 || det_inp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_clr: det_rst=%b det_inp=%b busy=%b, want 1 0 1", det_rst, det_inp, busy);
    end
    for (int i = 0; i < WIDTH; i++) begin
      step();
      checks++;
      if (det_inp !== word[i] || det_rst !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d: det_inp=%b det_rst=%b res_valid=%b, want %b 0 0",
                 i, det_inp, det_rst, res_valid, word[i]);
      end
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_count !== 5'd9 || res_mask !== 16'h5772) begin
      errors++;
      $display("FAIL single_result: valid=%b id=%b count=%0d mask=%h, want 1 0 9 5772",
               res_valid, res_id, res_count, res_mask);
    end
    step();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_count !== 5'd9 || res_mask !== 16'h5772) begin
      errors++;
      $display("FAIL single_hold: valid=%b busy=%b count=%0d mask=%h, want 0 0 9 5772",
               res_valid, busy, res_count, res_mask);
    end
  endtask

  task automatic test_tie();
    do_reset(2);
    req0_valid = 1'b1; req0_data = 16'hFFFF;
    req1_valid = 1'b1; req1_data = 16'h0000;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: r0rdy=%b r1rdy=%b, want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    for (int c = 2; c <= 18; c++) step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || res_count !== 5'd16 || res_mask !== 16'hFFFF || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_res0: valid=%b id=%b count=%0d mask=%h r1rdy=%b, want 1 0 16 ffff 0",
               res_valid, res_id, res_count, res_mask, req1_ready);
    end
    step();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_r1_accept: r1rdy=%b at cycle 19, want 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    for (int c = 21; c <= 37; c++) step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_count !== 5'd0 || res_mask !== 16'h0000) begin
      errors++;
      $display("FAIL tie_res1: valid=%b id=%b count=%0d mask=%h, want 1 1 0 0000",
               res_valid, res_id, res_count, res_mask);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_grant [4];
    int   grants [$];
    int   nres, last_res, cyc;
    exp_grant[0] = 1'b0; exp_grant[1] = 1'b1; exp_grant[2] = 1'b0; exp_grant[3] = 1'b1;
    nres = 0; last_res = -1; cyc = 0;
    req0_valid = 1'b1; req0_data = 16'h00F0;
    req1_valid = 1'b1; req1_data = 16'h0101;
    #1;
    while (nres < 4 && cyc < 200) begin
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (res_valid) begin
        checks++;
        if (nres >= grants.size() || res_id !== exp_grant[nres] ||
            res_count !== (exp_grant[nres] ? 5'd2 : 5'd4) ||
            res_mask !== (exp_grant[nres] ? 16'h0101 : 16'h00F0)) begin
          errors++;
          $display("FAIL b2b_res%0d: id=%b count=%0d mask=%h, want id %b", nres, res_id, res_count,
                   res_mask, exp_grant[nres]);
        end
        if (last_res >= 0) begin
          checks++;
          if (cyc - last_res != 19) begin
            errors++;
            $display("FAIL b2b_spacing%0d: %0d cycles, want 19", nres, cyc - last_res);
          end
        end
        last_res = cyc;
        nres++;
      end
      step();
      cyc++;
    end
    checks++;
    if (nres != 4) begin
      errors++;
      $display("FAIL b2b_timeout: %0d results within budget, want 4", nres);
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (g >= grants.size() || grants[g] != int'(exp_grant[g])) begin
        errors++;
        $display("FAIL b2b_grant%0d: got %0d, want %0d", g, (g < grants.size()) ? grants[g] : -1,
                 exp_grant[g]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (25) step();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    req0_valid = 1'b1; req0_data = 16'hFFFF;
    #1;
    step();
    req0_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (res_valid) stray++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (det_rst !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || det_inp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold: det_rst=%b busy=%b res_valid=%b det_inp=%b, want 1 0 0 0",
               det_rst, busy, res_valid, det_inp);
    end
    step(); step();
    req1_valid = 1'b1; req1_data = 16'h000F;
    rst = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_accept: r1rdy=%b r0rdy=%b, want 1 0", req1_ready, req0_ready);
    end
    step();
    req1_valid = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      step();
      if (res_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midrst_stray: %0d res_valid pulses from aborted job, want 0", stray);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_count !== 5'd4 || res_mask !== 16'h000F) begin
      errors++;
      $display("FAIL midrst_res: valid=%b id=%b count=%0d mask=%h, want 1 1 4 000f",
               res_valid, res_id, res_count, res_mask);
    end
    step();
    do_reset(1);
    req0_valid = 1'b1; req0_data = 16'h1234;
    req1_valid = 1'b1; req1_data = 16'h4321;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tie: r0rdy=%b r1rdy=%b, want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_reset(1);
  endtask

  task automatic test_late();
    int early;
    early = 0;
    req0_valid = 1'b1; req0_data = 16'h0003;
    #1;
    step();
    req0_valid = 1'b0;
    for (int c = 2; c <= 18; c++) begin
      step();
      if (c == 5) begin
        req1_valid = 1'b1; req1_data = 16'hC000;
        #1;
      end
      if (req1_ready) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL late_early: r1rdy high %0d times before cycle 19, want 0", early);
    end
    step();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_accept: r1rdy=%b at cycle 19, want 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    for (int c = 21; c <= 37; c++) step();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 1'b1 || res_count !== 5'd2 || res_mask !== 16'hC000) begin
      errors++;
      $display("FAIL late_res: valid=%b id=%b count=%0d mask=%h, want 1 1 2 c000",
               res_valid, res_id, res_count, res_mask);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_late();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
